seq_mult: RTL and testbench
===========================

// Module: seq_mult
// PURPOSE
//  Iterative shift-add multiplier. It is the responder side of the controller's
//  mult_reset / mult_load / mult_done handshake.
//  It multiplies ACC (op_a) by MDR (op_b), one partial product per clock.
//  It raises mult_done and holds the result stable until the controller loads it into ACC.
// PARAMETERS
//  WIDTH   8   operand width (ACC/MDR width); product is 2*WIDTH bits
//  CNT_W   4   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous reset, active-low
//  mult_reset    in   1        synchronous clear of the engine (level)
//  mult_load     in   1        start request; operands captured (level)
//  op_a          in   WIDTH    multiplicand (ACC)
//  op_b          in   WIDTH    multiplier (MDR)
//  mult_done     out  1        result valid, registered
//  mult_busy     out  1        iteration in progress, registered
//  mult_product  out  2*WIDTH  full unsigned product
//  mult_result   out  WIDTH    mult_product[WIDTH-1:0], the value written to ACC
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; mult_done=0; mult_busy=0; mult_product=0;
//    counter=0; operand registers=0. Takes effect immediately, mid-operation included.
//  States: IDLE, BUSY, DONE.
//  Priority at each edge: mult_reset > mult_load > iteration.
//  mult_reset=1, any state: next state IDLE; product, counter and operand regs
//    cleared; mult_done=0; mult_busy=0. Aborts a BUSY operation with no output.
//  IDLE & mult_load=1 & mult_reset=0:
//    - mcand<={WIDTH'b0,op_a}; mplier<=op_b; product<=0; cnt<=0.
//    - Next state BUSY; mult_busy=1.
//  BUSY, each cycle:
//    - if mplier[0], product<=product+mcand (2*WIDTH wrap-free).
//    - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
//    - mult_load ignored; a held load does not restart the operation.
//    - On the step where cnt==WIDTH-1: next state DONE, mult_done<=1, mult_busy<=0.
//  Latency: mult_done rises exactly WIDTH clocks after the capture edge.
//    No early termination, including for zero operands.
//  DONE:
//    - mult_done=1 and mult_product is held stable indefinitely.
//    - mult_load is ignored.
//    - Only mult_reset or rst_n leave DONE. A new multiply requires mult_reset, then mult_load.
//  mult_load and mult_reset both high in IDLE: reset wins, nothing captured.
//  Arithmetic:
//    - Operands are unsigned.
//    - mult_result, the low WIDTH bits, is also the correct two's-complement product
//      modulo 2**WIDTH, as the accumulator requires.
//    - mult_product never overflows 2*WIDTH bits.
//  Controller timing this block must satisfy:
//    - mult_reset is held 2 cycles, then mult_load is held 2 cycles.
//    - The controller polls mult_done and loads ACC the cycle after it sees mult_done=1.
//  mult_result is purely combinational from the product register.
// TESTING
//  1. op_a=3, op_b=5, reset 2 cyc, load 2 cyc -> mult_done high 8 clks after capture; product=16'h000F; result=8'h0F.
//  2. op_a=8'hFF, op_b=8'hFF -> product=16'hFE01; result=8'h01; done held 20 cycles with value unchanged.
//  3. op_a=8'hFF (-1), op_b=8'h03 -> result=8'hFD (-3); op_b=0 -> product=0, done still after exactly 8 clks.
//  4. Load held 2 cycles, operands changed on 2nd load cycle -> first-cycle operands used; busy one operation only.
//  5. mult_reset asserted at BUSY step 4 -> next edge IDLE, product=0, done never asserts; new op 6*7 -> 16'h002A.
//  6. rst_n pulsed low mid-BUSY, between clock edges -> outputs 0 immediately; load after release -> correct product.

Source files
------------

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
//   Iterative shift-add multiplier. Responder side of the controller's
//   mult_reset / mult_load / mult_done handshake. Multiplies op_a (ACC) by
//   op_b (MDR), one partial product per clock. The product appears WIDTH
//   clocks after the operands are captured. It is then held, with mult_done
//   high, until the controller clears the engine with mult_reset.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous reset, active-low
//   mult_reset    synchronous clear of the engine (level, highest priority)
//   mult_load     start request; operands captured in IDLE (level)
//   op_a          multiplicand, unsigned, WIDTH bits
//   op_b          multiplier, unsigned, WIDTH bits
//   mult_done     result valid (registered)
//   mult_busy     iteration in progress (registered)
//   mult_product  full 2*WIDTH-bit unsigned product
//   mult_result   low WIDTH bits of the product (value written back to ACC)
// -----------------------------------------------------------------------------
module seq_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mult_reset,
    input  logic                 mult_load,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 mult_done,
    output logic                 mult_busy,
    output logic [2*WIDTH-1:0]   mult_product,
    output logic [WIDTH-1:0]     mult_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_next;
    logic                 done_next;
    logic                 busy_next;
    logic                 last_step;

    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;

    assign last_step = (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: mult_reset beats mult_load beats iteration.
    // Once in DONE only mult_reset (or rst_n) gets the engine back to IDLE.
    always_comb begin
        state_next = state;
        if (mult_reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (mult_load) state_next = BUSY;
                BUSY:    if (last_step) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode from the next state, so the flags are registered
    // and change on the same edge as the state itself.
    always_comb begin
        done_next = (state_next == DONE);
        busy_next = (state_next == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_done <= 1'b0;
            mult_busy <= 1'b0;
        end else begin
            mult_done <= done_next;
            mult_busy <= busy_next;
        end
    end

    // Shift-add datapath. The multiplicand is zero-extended to 2*WIDTH and
    // shifted left each step, so the accumulated sum of WIDTH partial
    // products always fits in 2*WIDTH bits. No early exit on zero operands:
    // latency is fixed at WIDTH steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
        end else if (mult_reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
        end else if (state == IDLE && mult_load) begin
            mcand   <= {{WIDTH{1'b0}}, op_a};
            mplier  <= op_b;
            product <= '0;
            cnt     <= '0;
        end else if (state == BUSY) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Low half is also the two's-complement product modulo 2**WIDTH.
    assign mult_product = product;
    assign mult_result  = product[WIDTH-1:0];

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               mult_reset;
    logic               mult_load;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               mult_done;
    logic               mult_busy;
    logic [2*WIDTH-1:0] mult_product;
    logic [WIDTH-1:0]   mult_result;

    seq_mult #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mult_reset   (mult_reset),
        .mult_load    (mult_load),
        .op_a         (op_a),
        .op_b         (op_b),
        .mult_done    (mult_done),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .mult_result  (mult_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   res;
        int                 cyc;
        string              name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: on each rising edge of mult_done, pop the oldest expectation
    // and compare product, result and the cycle the flag appeared.
    logic prev_done = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (mult_done && !prev_done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, 32'(mult_product), 32'(e.prod));
                check({e.name, "_result"},  32'(mult_result),  32'(e.res));
                check({e.name, "_latency"}, 32'(cyc),          32'(e.cyc));
            end
        end
        prev_done = mult_done;
    end

    // Clear for 2 cycles, then raise mult_load with the operands. Returns at
    // the negedge where load was first driven (the capture edge is next).
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit push, input logic [2*WIDTH-1:0] ep,
                            input logic [WIDTH-1:0] er, input string name);
        exp_t e;
        @(negedge clk);
        mult_reset = 1'b1;
        mult_load  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mult_reset = 1'b0;
        mult_load  = 1'b1;
        op_a       = a;
        op_b       = b;
        if (push) begin
            e.prod = ep;
            e.res  = er;
            e.cyc  = cyc + 1 + WIDTH;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // Second load cycle (optionally with new operands), drop load, then
    // wait for mult_done while counting busy cycles.
    task automatic wait_done(input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2,
                             input string name);
        int busy_cnt = 0;
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                op_a = a2;
                op_b = b2;
            end
            if (i == 1) mult_load = 1'b0;
            if (mult_busy) busy_cnt++;
            if (mult_done) begin
                got = 1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    endtask

    initial begin
        bit seen;
        rst_n      = 1'b0;
        mult_reset = 1'b0;
        mult_load  = 1'b0;
        op_a       = '0;
        op_b       = '0;

        #12;
        check("reset_done",    32'(mult_done),    32'd0);
        check("reset_busy",    32'(mult_busy),    32'd0);
        check("reset_product", 32'(mult_product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 * 5
        start_op(8'd3, 8'd5, 1, 16'h000F, 8'h0F, "t1");
        wait_done(8'd3, 8'd5, "t1");

        // 255 * 255, then hold DONE for 20 cycles while load toggles
        start_op(8'hFF, 8'hFF, 1, 16'hFE01, 8'h01, "t2");
        wait_done(8'hFF, 8'hFF, "t2");
        for (int i = 0; i < 20; i++) begin
            mult_load = i[0];
            op_a      = 8'(i);
            @(negedge clk);
            check("t2_hold_done",    32'(mult_done),    32'd1);
            check("t2_hold_product", 32'(mult_product), 32'hFE01);
        end
        mult_load = 1'b0;

        // -1 * 3 -> -3 in the low byte
        start_op(8'hFF, 8'h03, 1, 16'h02FD, 8'hFD, "t3a");
        wait_done(8'hFF, 8'h03, "t3a");

        // zero multiplier: no early termination
        start_op(8'hA5, 8'h00, 1, 16'h0000, 8'h00, "t3b");
        wait_done(8'hA5, 8'h00, "t3b");

        // operands changed on second load cycle are ignored: 0x12*0x34
        start_op(8'h12, 8'h34, 1, 16'h03A8, 8'hA8, "t4");
        wait_done(8'h77, 8'h99, "t4");

        // reset and load together in IDLE: reset wins
        @(negedge clk);
        mult_reset = 1'b1;
        mult_load  = 1'b1;
        op_a       = 8'h09;
        op_b       = 8'h09;
        @(negedge clk);
        mult_reset = 1'b0;
        mult_load  = 1'b0;
        @(negedge clk);
        check("both_high_busy",    32'(mult_busy),    32'd0);
        check("both_high_product", 32'(mult_product), 32'd0);

        // abort with mult_reset at BUSY step 4
        start_op(8'h55, 8'h33, 0, '0, '0, "t5a");
        @(negedge clk);
        @(negedge clk);
        mult_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before_abort", 32'(mult_busy), 32'd1);
        mult_reset = 1'b1;
        @(negedge clk);
        check("t5_abort_busy",    32'(mult_busy),    32'd0);
        check("t5_abort_done",    32'(mult_done),    32'd0);
        check("t5_abort_product", 32'(mult_product), 32'd0);
        mult_reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (mult_done) seen = 1;
        end
        check("t5_no_done_after_abort", 32'(seen), 32'd0);
        start_op(8'd6, 8'd7, 1, 16'h002A, 8'h2A, "t5b");
        wait_done(8'd6, 8'd7, "t5b");

        // asynchronous reset between edges mid-BUSY
        start_op(8'hC3, 8'h5A, 0, '0, '0, "t6a");
        @(negedge clk);
        @(negedge clk);
        mult_load = 1'b0;
        @(negedge clk);
        check("t6_busy_before_rst", 32'(mult_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",    32'(mult_busy),    32'd0);
        check("t6_rst_done",    32'(mult_done),    32'd0);
        check("t6_rst_product", 32'(mult_product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h0D, 8'h0B, 1, 16'h008F, 8'h8F, "t6b");
        wait_done(8'h0D, 8'h0B, "t6b");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
